// File: rtl/req_gnt_requester.sv
// ---------------------------------------------------------------------------
// req_gnt_requester
//
// Upstream side of the req/gnt handshake. A round-robin arbiter picks one of
// NUM_CLIENTS level requests. It issues a single-cycle req_op toward the
// target and waits up to TIMEOUT cycles for gnt_ip. It then returns a
// one-hot done or err pulse to the selected client. Every transaction ends
// with a mandatory GAP cycle and an IDLE cycle, so req_op pulses are at
// least four cycles apart. gnt_ip seen outside WAIT is counted as spurious
// and never completes a transaction.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; pick next requesting client from rr_ptr upward
// REQ   | req_op high for this single cycle
// WAIT  | waiting for gnt_ip; wait_rem counts down toward abort
// GAP   | done/err (and late) pulse for sel_op; advance rr_ptr
//
// Ports
//   clk_ip       in   clock, rising edge
//   reset_n_ip   in   asynchronous active-low reset
//   cl_req_ip    in   per-client level request, held until done/err
//   gnt_ip       in   grant from target
//   req_op       out  one-cycle request pulse to target
//   sel_op       out  index of the client being served (REQ..GAP)
//   cl_done_op   out  one-hot pulse, request granted
//   cl_err_op    out  one-hot pulse, timed out without grant
//   late_op      out  pulse, grant came after the first WAIT cycle
//   busy_op      out  high in REQ, WAIT and GAP
//   spur_cnt_op  out  saturating count of gnt_ip seen outside WAIT
// ---------------------------------------------------------------------------
module req_gnt_requester #(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 8,
    localparam int IDX_W      = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk_ip,
    input  logic                   reset_n_ip,
    input  logic [NUM_CLIENTS-1:0] cl_req_ip,
    input  logic                   gnt_ip,
    output logic                   req_op,
    output logic [IDX_W-1:0]       sel_op,
    output logic [NUM_CLIENTS-1:0] cl_done_op,
    output logic [NUM_CLIENTS-1:0] cl_err_op,
    output logic                   late_op,
    output logic                   busy_op,
    output logic [7:0]             spur_cnt_op
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]       wait_rem;

    logic [NUM_CLIENTS-1:0] req_rot;
    logic [IDX_W-1:0]       pick_off;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic [IDX_W-1:0]       rr_next;

    // Rotate requests so bit 0 is the client at rr_ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset.
    assign req_rot = NUM_CLIENTS'({cl_req_ip, cl_req_ip} >> rr_ptr);

    // Descending scan: the lowest set offset is written last and wins.
    always_comb begin
        pick_off = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = IDX_W'(i);
            end
        end
    end

    // Undo the rotation modulo NUM_CLIENTS (works for non power-of-two).
    always_comb begin
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W + 1)'(NUM_CLIENTS)) begin
            pick_idx = IDX_W'(pick_sum - (IDX_W + 1)'(NUM_CLIENTS));
        end else begin
            pick_idx = pick_sum[IDX_W-1:0];
        end
    end

    assign sel_onehot = {{(NUM_CLIENTS - 1){1'b0}}, 1'b1} << sel_op;
    assign rr_next    = (sel_op == IDX_W'(NUM_CLIENTS - 1)) ? '0 : sel_op + 1'b1;

    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            wait_rem    <= '0;
            req_op      <= 1'b0;
            sel_op      <= '0;
            cl_done_op  <= '0;
            cl_err_op   <= '0;
            late_op     <= 1'b0;
            busy_op     <= 1'b0;
            spur_cnt_op <= '0;
        end else begin
            req_op     <= 1'b0;
            cl_done_op <= '0;
            cl_err_op  <= '0;
            late_op    <= 1'b0;

            // Only a WAIT-cycle grant is legitimate; anything else is noise.
            if (gnt_ip && (state != ST_WAIT) && (spur_cnt_op != 8'hFF)) begin
                spur_cnt_op <= spur_cnt_op + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (|cl_req_ip) begin
                        sel_op  <= pick_idx;
                        req_op  <= 1'b1;
                        busy_op <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    wait_rem <= CNT_W'(TIMEOUT);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A grant on the final WAIT cycle still wins over timeout.
                    if (gnt_ip) begin
                        cl_done_op <= sel_onehot;
                        late_op    <= (wait_rem != CNT_W'(TIMEOUT));
                        state      <= ST_GAP;
                    end else if (wait_rem == CNT_W'(1)) begin
                        cl_err_op <= sel_onehot;
                        state     <= ST_GAP;
                    end else begin
                        wait_rem <= wait_rem - 1'b1;
                    end
                end
                ST_GAP: begin
                    rr_ptr  <= rr_next;
                    busy_op <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
